// File: rtl/mem_arb_pkg.sv
// Shared constants for the two-port memory arbiter: FSM encodings, port indices
// and the state-sequencing helper used by the top level.
package mem_arb_pkg;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    localparam logic PORT_IF   = 1'b0;
    localparam logic PORT_DATA = 1'b1;

    // Every accepted request walks IDLE -> ACCESS -> RESP -> IDLE.
    function automatic logic [1:0] next_state(input logic [1:0] state, input logic accept);
        logic [1:0] nxt;
        case (state)
            IDLE:    nxt = accept ? ACCESS : IDLE;
            ACCESS:  nxt = RESP;
            default: nxt = IDLE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin picker: on contention the port that did not win
// last time is chosen; a lone requester always wins.
module rr_arb2 (
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    output logic grant,
    output logic any_grant
);
    assign any_grant = valid0 | valid1;
    assign grant     = (valid0 && valid1) ? ~last_grant : valid1;
endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one shared
// single-cycle memory; each transaction is accept, access, respond.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int W         = 4,
    parameter int Addr_W    = 8,
    parameter int MEM_BYTES = 51
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [Addr_W-1:0] req0_addr,
    input  logic [8*W-1:0]    req0_wdata,
    input  logic              req0_we,
    output logic              req0_ready,
    output logic              rsp0_valid,
    output logic [8*W-1:0]    rsp0_rdata,
    output logic              rsp0_err,
    input  logic              req1_valid,
    input  logic [Addr_W-1:0] req1_addr,
    input  logic [8*W-1:0]    req1_wdata,
    input  logic              req1_we,
    output logic              req1_ready,
    output logic              rsp1_valid,
    output logic [8*W-1:0]    rsp1_rdata,
    output logic              rsp1_err,
    output logic [Addr_W-1:0] mem_addr,
    output logic [8*W-1:0]    mem_wdata,
    output logic              mem_we,
    input  logic [8*W-1:0]    mem_rdata
);

    // Range check is done one bit wider than the address so addr+W-1 cannot wrap.
    localparam logic [Addr_W:0] LAST_OFS = (Addr_W+1)'(W - 1);
    localparam logic [Addr_W:0] MAX_BYTE = (Addr_W+1)'(MEM_BYTES - 1);

    logic [1:0]        state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic [Addr_W-1:0] addr_q, addr_d;
    logic [8*W-1:0]    wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              port_q, port_d;
    logic [8*W-1:0]    rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    logic              grant;
    logic              any_grant;
    logic              accept;
    logic [Addr_W:0]   last_byte;
    logic              in_range;
    logic              in_access;
    logic              in_resp;

    rr_arb2 u_rr_arb2 (
        .valid0     (req0_valid),
        .valid1     (req1_valid),
        .last_grant (last_grant_q),
        .grant      (grant),
        .any_grant  (any_grant)
    );

    assign accept    = (state_q == IDLE) && any_grant;
    assign last_byte = {1'b0, addr_q} + LAST_OFS;
    assign in_range  = (last_byte <= MAX_BYTE);
    assign in_access = (state_q == ACCESS) && !reset;
    assign in_resp   = (state_q == RESP) && !reset;

    always_comb begin
        state_d      = next_state(state_q, accept);
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        we_d         = we_q;
        port_d       = port_q;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_err_d    = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    last_grant_d = grant;
                    port_d       = grant;
                    addr_d       = (grant == PORT_DATA) ? req1_addr  : req0_addr;
                    wdata_d      = (grant == PORT_DATA) ? req1_wdata : req0_wdata;
                    we_d         = (grant == PORT_DATA) ? req1_we    : req0_we;
                end
            end
            ACCESS: begin
                rsp_rdata_d = (!we_q && in_range) ? mem_rdata : '0;
                rsp_err_d   = !in_range;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= PORT_DATA;
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            port_q       <= PORT_IF;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            port_q       <= port_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign req0_ready = !reset && accept && (grant == PORT_IF);
    assign req1_ready = !reset && accept && (grant == PORT_DATA);

    assign mem_addr  = in_access ? addr_q  : '0;
    assign mem_wdata = in_access ? wdata_q : '0;
    assign mem_we    = in_access && we_q && in_range;

    assign rsp0_valid = in_resp && (port_q == PORT_IF);
    assign rsp1_valid = in_resp && (port_q == PORT_DATA);
    assign rsp0_rdata = rsp0_valid ? rsp_rdata_q : '0;
    assign rsp1_rdata = rsp1_valid ? rsp_rdata_q : '0;
    assign rsp0_err   = rsp0_valid && rsp_err_q;
    assign rsp1_err   = rsp1_valid && rsp_err_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter W, default 4, bytes per word transferred per access.
REQ-002 Parameter Addr_W, default 8, byte-address width.
REQ-003 Parameter MEM_BYTES, default 51, number of implemented memory bytes (valid byte addresses 0..MEM_BYTES-1).
REQ-004 Ports, one per line, SHALL be:
 clk  in  1  single clock; all state updates on posedge.
 reset  in  1  synchronous, active-high reset.
 req0_valid  in  1  port 0 (instruction fetch) request.
 req0_addr  in  Addr_W  port 0 byte address.
 req0_wdata  in  8*W  port 0 write data.
 req0_we  in  1  port 0 write (1) / read (0).
 req0_ready  out  1  port 0 request accepted this cycle.
 rsp0_valid  out  1  port 0 response valid.
 rsp0_rdata  out  8*W  port 0 read data.
 rsp0_err  out  1  port 0 out-of-range error.
 req1_valid / req1_addr / req1_wdata / req1_we / req1_ready / rsp1_valid / rsp1_rdata / rsp1_err: same as port 0, for port 1 (data access).
 mem_addr  out  Addr_W  address to shared memory.
 mem_wdata  out  8*W  write data to shared memory.
 mem_we  out  1  write enable to shared memory.
 mem_rdata  in  8*W  combinational read data from shared memory.

Function
REQ-005 FSM states SHALL be IDLE, ACCESS, RESP; transitions IDLE->ACCESS on acceptance, ACCESS->RESP unconditionally, RESP->IDLE unconditionally.
REQ-006 In IDLE with any reqN_valid high, exactly one port SHALL be granted; reqN_ready SHALL be high for that port only, in that same cycle (combinational), and addr/wdata/we/port SHALL be latched at that edge.
REQ-007 Arbitration SHALL be round-robin: with both valid, the port not granted most recently wins; with one valid, that port wins.
REQ-008 reqN_ready SHALL be 0 in ACCESS and RESP; a requester SHALL hold valid and fields stable until ready.
REQ-009 In ACCESS, mem_addr/mem_wdata SHALL equal latched values and mem_we SHALL equal latched we AND in-range AND NOT reset; in IDLE and RESP mem_addr, mem_wdata, mem_we SHALL be 0.
REQ-010 A request SHALL be in-range iff addr + W - 1 <= MEM_BYTES - 1, computed at Addr_W+1 bits (no wrap-around); out-of-range requests SHALL perform no memory write.
REQ-011 At the ACCESS->RESP edge, the response register SHALL capture mem_rdata for in-range reads, 0 for writes or out-of-range requests.
REQ-012 In RESP, rspN_valid SHALL be high for exactly one cycle on the granted port only, with rspN_rdata and rspN_err (1 iff out-of-range) valid that cycle; writes also produce a response.
REQ-013 Latency: request accepted in cycle T -> memory access in T+1 -> response in T+2; next acceptance no earlier than T+3.
REQ-014 rspN_rdata and rspN_err SHALL be 0 whenever rspN_valid is 0.

Reset
REQ-015 With reset high at a posedge, state SHALL become IDLE, round-robin pointer SHALL favour port 0 next, all latched fields and response registers SHALL clear to 0.
REQ-016 While reset is high, all outputs SHALL be 0 (including reqN_ready); reset asserted during ACCESS SHALL suppress the write and drop the pending response.

Structure
REQ-017 Shared package mem_arb_pkg SHALL hold state encodings (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2) and port index constants PORT_IF=0, PORT_DATA=1.
REQ-018 Round-robin selection SHALL be a sub-module rr_arb2 (inputs: two valids, last-grant; outputs: grant index, any-grant); the shared memory is instantiated outside this block.

Verification
REQ-019 Bench SHALL cover, with memory W=4, MEM_BYTES=51 attached:
 - Port 1 write addr 8, data 32'hDEADBEEF -> req1_ready cycle T, mem_we=1 at T+1, rsp1_valid at T+2 with err=0, rdata=0; then port 0 read addr 8 -> rsp0_rdata=32'hDEADBEEF.
 - Both valid continuously after reset -> grants alternate 0,1,0,1; each accepted every 3 cycles.
 - Port 0 read addr 47 (47+3=50) -> err=0; addr 48 -> rsp0_err=1, rdata=0, mem_we never high.
 - Port 1 write addr 8'hFE -> err=1, no memory write (no wrap to bytes 0..1; bytes 0..1 unchanged).
 - Reset asserted in ACCESS of write addr 4 -> mem_we=0 that cycle, no rsp, memory bytes 4..7 unchanged, next grant to port 0.
